// File: rtl/rom_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_if
// Brief    : Byte-stream input and instruction-RAM write bus of rom_loader.
//            The master modport is the loader and the slave modport is the
//            byte source / instruction RAM / CPU reset side.
// Revision : 1.0 - initial release
// ============================================================================
interface rom_loader_if #(
    parameter int ROM_WIDTH  = 21,
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ROM_WIDTH-1:0]  wr_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Brief    : Power-up program loader. Receives a byte stream (16-bit word
//            count, then 3 bytes per instruction word, big-endian), writes
//            each assembled word to instruction RAM and holds the CPU in
//            reset until the image is complete.
//            Optional feature macro: ROM_LOADER_CHECKSUM_EN - a trailing XOR
//            checksum byte over all payload bytes is verified; a mismatch
//            ends in the sticky error state.
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader #(
    parameter int ROM_WIDTH  = 21,
    parameter int ADDR_WIDTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    rom_loader_if.master    bus
);
    // Width wide enough to compare "words written" against the 16-bit count
    // without overflow whatever ADDR_WIDTH is.
    localparam int c_CMPW = ((ADDR_WIDTH > 16) ? ADDR_WIDTH : 16) + 1;

    typedef enum logic [3:0] {
        S_CNT_HI = 4'd0,
        S_CNT_LO = 4'd1,
        S_B0     = 4'd2,
        S_B1     = 4'd3,
        S_B2     = 4'd4,
        S_WRITE  = 4'd5,
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CHECK  = 4'd6,
`endif
        S_DONE   = 4'd7,
        S_ERROR  = 4'd8
    } state_t;

    // State entered once the last word is written (or directly when N = 0).
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t c_END = S_CHECK;
`else
    localparam state_t c_END = S_DONE;
`endif

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_more;

    logic [7:0]             r_cnt_hi;
    logic [15:0]            r_cnt;
    logic [ROM_WIDTH-17:0]  r_b0;   // only the B0 bits that reach the word
    logic [7:0]             r_b1;
    logic                   r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [ROM_WIDTH-1:0]   r_wr_data;
    logic                   r_cpu_hold;
    logic                   r_done;

    // Ready is decoded straight from state so a byte can be taken each cycle.
`ifdef ROM_LOADER_CHECKSUM_EN
    assign w_ready = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                     (r_state == S_B0) || (r_state == S_B1) ||
                     (r_state == S_B2) || (r_state == S_CHECK);
`else
    assign w_ready = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                     (r_state == S_B0) || (r_state == S_B1) ||
                     (r_state == S_B2);
`endif
    assign w_accept = bus.rx_valid && w_ready;

    // The address register doubles as the word index, so after the current
    // write the number of words written is r_wr_addr + 1.
    assign w_more = (c_CMPW'(r_wr_addr) + c_CMPW'(1)) < c_CMPW'(r_cnt);

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_error;

    // Running XOR of payload bytes; cleared while waiting for a new stream.
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_CNT_HI)) begin
            r_xor <= 8'h00;
        end else if (w_accept &&
                     ((r_state == S_B0) || (r_state == S_B1) ||
                      (r_state == S_B2))) begin
            r_xor <= r_xor ^ bus.rx_data;
        end
    end

    // Sticky error flag follows entry into the error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else begin
            r_error <= (w_state_next == S_ERROR);
        end
    end

    assign bus.error = r_error;
`else
    assign bus.error = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CNT_HI: if (w_accept) w_state_next = S_CNT_LO;
            S_CNT_LO: begin
                if (w_accept) begin
                    w_state_next = ({r_cnt_hi, bus.rx_data} == 16'd0) ? c_END : S_B0;
                end
            end
            S_B0:     if (w_accept) w_state_next = S_B1;
            S_B1:     if (w_accept) w_state_next = S_B2;
            S_B2:     if (w_accept) w_state_next = S_WRITE;
            S_WRITE:  w_state_next = w_more ? S_B0 : c_END;
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_accept) begin
                    w_state_next = (bus.rx_data == r_xor) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE:   w_state_next = S_DONE;
            S_ERROR:  w_state_next = S_ERROR;
            default:  w_state_next = S_CNT_HI;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CNT_HI;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Byte capture, word assembly, address counting and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_hi   <= 8'h00;
            r_cnt      <= 16'h0000;
            r_b0       <= '0;
            r_b1       <= 8'h00;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                case (r_state)
                    S_CNT_HI: r_cnt_hi  <= bus.rx_data;
                    S_CNT_LO: r_cnt     <= {r_cnt_hi, bus.rx_data};
                    S_B0:     r_b0      <= bus.rx_data[ROM_WIDTH-17:0];
                    S_B1:     r_b1      <= bus.rx_data;
                    S_B2:     r_wr_data <= {r_b0, r_b1, bus.rx_data};
                    default:  ;
                endcase
            end
            if (r_state == S_WRITE) begin
                r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
            end
            r_wr_en    <= (w_state_next == S_WRITE);
            r_done     <= (w_state_next == S_DONE);
            r_cpu_hold <= (w_state_next != S_DONE);
        end
    end

    assign bus.rx_ready = w_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.cpu_hold = r_cpu_hold;
    assign bus.done     = r_done;
endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_loader
// Brief    : Self-checking bench for rom_loader: table of directed streams,
//            mid-load reset sequence and randomized loads with gaps, checked
//            against a stream-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_loader;
    localparam int c_RW = 21;
    localparam int c_AW = 16;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam bit c_CHK = 1'b1;
`else
    localparam bit c_CHK = 1'b0;
`endif

    logic clk;
    logic rst;

    rom_loader_if #(.ROM_WIDTH(c_RW), .ADDR_WIDTH(c_AW)) bus ();

    rom_loader #(.ROM_WIDTH(c_RW), .ADDR_WIDTH(c_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor state, sampled on the falling edge.
    int         nwr = 0;
    logic [31:0] first_data = 0;
    logic [31:0] last_data  = 0;
    int         ready_in_write = 0;

    logic [7:0] stream[$];

    typedef struct {
        string       name;
        int          len;
        logic [87:0] bytes;     // right-aligned, first byte most significant
        int          exp_nwr;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t tbl[$];

    // Write monitor.
    always @(negedge clk) begin
        if (rst) begin
            nwr = 0;
        end else if (bus.wr_en) begin
            if (nwr == 0) first_data = 32'(bus.wr_data);
            last_data = 32'(bus.wr_data);
            nwr++;
            if (bus.rx_ready) ready_in_write++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Offer one byte after an idle gap; ok=0 if it is never accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        bus.rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.rx_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        bus.rx_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Drive the whole stream and compare against the stream-level model.
    task automatic run_stream(input int maxgap);
        int n;
        int w;
        int leak;
        int nwr_end;
        logic [7:0] x;
        bit err;
        bit ok;
        n = int'(stream[0]) * 256 + int'(stream[1]);
        x = 8'h00;
        for (int i = 0; i < 3 * n; i++) x = x ^ stream[2 + i];
        err = c_CHK && (stream[2 + 3 * n] != x);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], (i == 0) ? 0 : int'($urandom_range(0, maxgap)), ok);
            if (!ok) return;
            if (i >= 2 && (i - 2) < 3 * n && ((i - 2) % 3) == 2) begin
                w = (int'(stream[i - 2]) * 65536 + int'(stream[i - 1]) * 256 +
                     int'(stream[i])) % (1 << c_RW);
                check("wr_en_after_b2", 32'(bus.wr_en), 32'd1);
                check("wr_addr", 32'(bus.wr_addr), 32'((i - 2) / 3));
                check("wr_data", 32'(bus.wr_data), 32'(w));
            end
        end
        if (!c_CHK && n > 0) begin
            @(posedge clk);
            #1;
        end
        check("done", 32'(bus.done), 32'(!err));
        check("error", 32'(bus.error), 32'(err));
        check("cpu_hold", 32'(bus.cpu_hold), 32'(err));
        check("write_count", 32'(nwr), 32'(n));
        nwr_end = nwr;
        leak = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'($urandom);
        repeat (3) begin
            @(negedge clk);
            if (bus.rx_ready) leak++;
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        check("ready_after_end", 32'(leak), 32'd0);
        check("no_write_after_end", 32'(nwr), 32'(nwr_end));
    endtask

    function automatic void add(input string nm, input int len, input logic [87:0] b,
                                input int nw, input logic [31:0] f, input logic [31:0] l,
                                input bit d, input bit e);
        vec_t v;
        v.name = nm; v.len = len; v.bytes = b; v.exp_nwr = nw;
        v.exp_first = f; v.exp_last = l; v.exp_done = d; v.exp_err = e;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [87:0] tmp;
        bit ok;
        int n;
        logic [7:0] x;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

`ifdef ROM_LOADER_CHECKSUM_EN
        add("basic", 9, 88'h00_02_02_00_02_04_00_00_04, 2, 32'h020002, 32'h040000, 1, 0);
        add("mask",  6, 88'h00_01_FF_12_34_D9,          1, 32'h1F1234, 32'h1F1234, 1, 0);
        add("n0",    3, 88'h00_00_00,                   0, 32'h0,      32'h0,      1, 0);
        add("badcs", 9, 88'h00_02_02_00_02_04_00_00_05, 2, 32'h020002, 32'h040000, 0, 1);
`else
        add("basic", 8, 88'h00_02_02_00_02_04_00_00,    2, 32'h020002, 32'h040000, 1, 0);
        add("mask",  5, 88'h00_01_FF_12_34,             1, 32'h1F1234, 32'h1F1234, 1, 0);
        add("n0",    2, 88'h00_00,                      0, 32'h0,      32'h0,      1, 0);
`endif

        // Reset values.
        do_reset();
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        check("rst_wr_data",  32'(bus.wr_data),  32'd0);
        check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_error",    32'(bus.error),    32'd0);

        // Directed table.
        for (int t = 0; t < tbl.size(); t++) begin
            do_reset();
            stream = {};
            for (int i = 0; i < tbl[t].len; i++) begin
                tmp = tbl[t].bytes >> (8 * (tbl[t].len - 1 - i));
                stream.push_back(tmp[7:0]);
            end
            run_stream(0);
            check({tbl[t].name, "_nwr"},   32'(nwr),          32'(tbl[t].exp_nwr));
            check({tbl[t].name, "_done"},  32'(bus.done),     32'(tbl[t].exp_done));
            check({tbl[t].name, "_err"},   32'(bus.error),    32'(tbl[t].exp_err));
            check({tbl[t].name, "_hold"},  32'(bus.cpu_hold), 32'(!tbl[t].exp_done));
            if (tbl[t].exp_nwr > 0) begin
                check({tbl[t].name, "_first"}, first_data, tbl[t].exp_first);
                check({tbl[t].name, "_last"},  last_data,  tbl[t].exp_last);
            end
        end

        // Reset after B1 of word 3 of a 4-word load, then a clean 2-word load.
        do_reset();
        stream = '{8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33, 8'h5A, 8'hA5};
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], 0, ok);
        end
        check("midload_partial_writes", 32'(nwr), 32'd2);
        check("midload_hold", 32'(bus.cpu_hold), 32'd1);
        do_reset();
        check("midload_addr_cleared", 32'(bus.wr_addr), 32'd0);
        stream = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A};
        if (c_CHK) stream.push_back(8'h01 ^ 8'h23 ^ 8'h45 ^ 8'h06 ^ 8'h78 ^ 8'h9A);
        run_stream(3);
        check("midload_first", first_data, 32'h012345);
        check("midload_last",  last_data,  32'h06789A);

        // Randomized loads with idle gaps and held valid across writes.
        for (int r = 0; r < 20; r++) begin
            do_reset();
            n = int'($urandom_range(1, 6));
            stream = {};
            stream.push_back(8'(n >> 8));
            stream.push_back(8'(n));
            x = 8'h00;
            for (int i = 0; i < 3 * n; i++) begin
                stream.push_back(8'($urandom));
                x = x ^ stream[stream.size() - 1];
            end
            if (c_CHK) stream.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'h01) : x);
            run_stream(5);
        end

        check("ready_during_write", 32'(ready_in_write), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
